// File: rtl/tinker_mem_pkg.sv
// Shared types and default parameter values for the tinker memory controller.
package tinker_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } mem_gnt_e;

  localparam int INST_BYTES     = 4;
  localparam int DEF_ADDR_W     = 64;
  localparam int DEF_MEM_BYTES  = 524288;
  localparam int DEF_DATA_BYTES = 8;
  localparam int DEF_LATENCY    = 2;

endpackage

// File: rtl/tinker_mem_arb.sv
// Two-way alternating-priority arbiter between the fetch and data channels.
// On a tie the channel that did not win last time is granted; the pointer
// starts at the fetch channel so the data channel wins the first tie.
module tinker_mem_arb
  import tinker_mem_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     req_if_i,
  input  logic     req_d_i,
  input  logic     accept_i,
  output mem_gnt_e grant_o
);

  mem_gnt_e last_q;
  mem_gnt_e last_d;

  // Grant selection purely from the two valids and the last-grant pointer
  always_comb begin
    grant_o = GNT_IF;
    if (req_if_i && req_d_i) begin
      if (last_q == GNT_IF) grant_o = GNT_D;
      else                  grant_o = GNT_IF;
    end else if (req_d_i) begin
      grant_o = GNT_D;
    end
  end

  // Pointer only moves when the engine actually takes a request
  always_comb begin
    last_d = last_q;
    if (accept_i) last_d = grant_o;
  end

  // Last-grant pointer register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= GNT_IF;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/tinker_mem_ctrl.sv
// Shared single-engine memory controller: one byte array serves a 32-bit
// fetch channel and a DATA_BYTES-wide data channel, each with a valid/ready
// request and a one-cycle response strobe LATENCY edges after acceptance.
module tinker_mem_ctrl
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MEM_BYTES  = DEF_MEM_BYTES,
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_W-1:0]       if_req_addr,
  output logic                    if_rsp_valid,
  output logic [31:0]             if_rsp_data,
  output logic                    if_rsp_err,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic                    d_req_we,
  input  logic [ADDR_W-1:0]       d_req_addr,
  input  logic [DATA_BYTES*8-1:0] d_req_wdata,
  input  logic [DATA_BYTES-1:0]   d_req_be,
  output logic                    d_rsp_valid,
  output logic [DATA_BYTES*8-1:0] d_rsp_rdata,
  output logic                    d_rsp_err,
  output logic                    busy
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int DW = DATA_BYTES * 8;

  logic [7:0] mem [MEM_BYTES];

  mem_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  mem_gnt_e        ch_q, ch_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  mem_gnt_e        grant;
  logic            engine_free;
  logic            accept;
  logic            rsp_fire;
  logic            is_write;
  logic            req_err;
  logic            wr_en;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W:0]   req_size;
  logic [ADDR_W:0]   req_end;
  logic [AW-1:0]     base;
  logic [DW-1:0]     rd_word;

  tinker_mem_arb u_arb (
    .clock    (clock),
    .reset    (reset),
    .req_if_i (if_req_valid),
    .req_d_i  (d_req_valid),
    .accept_i (accept),
    .grant_o  (grant)
  );

  // Engine availability, handshakes and the range check of the granted request.
  // The end address is formed one bit wider than the address so it cannot wrap.
  always_comb begin
    rsp_fire     = (state_q == BUSY) && (cnt_q == CW'(LATENCY));
    engine_free  = (state_q == IDLE) || rsp_fire;
    if_req_ready = engine_free && (grant == GNT_IF);
    d_req_ready  = engine_free && (grant == GNT_D);
    accept       = reset && ((if_req_valid && if_req_ready) || (d_req_valid && d_req_ready));
    req_addr     = (grant == GNT_D) ? d_req_addr : if_req_addr;
    req_size     = (grant == GNT_D) ? (ADDR_W+1)'(DATA_BYTES) : (ADDR_W+1)'(INST_BYTES);
    req_end      = {1'b0, req_addr} + req_size;
    req_err      = req_end > (ADDR_W+1)'(MEM_BYTES);
    is_write     = (grant == GNT_D) && d_req_we;
    base         = req_addr[AW-1:0];
    wr_en        = accept && is_write && !req_err;
  end

  // Little-endian gather of the bytes starting at the request address
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      rd_word[i*8 +: 8] = mem[base + AW'(i)];
    end
  end

  // Engine sequencing: accept latches channel/error/data, then count to LATENCY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (accept) begin
      state_d = BUSY;
      cnt_d   = CW'(1);
      ch_d    = grant;
      err_d   = req_err;
      if (is_write || req_err)  rdata_d = '0;
      else if (grant == GNT_IF) rdata_d = DW'(rd_word[31:0]);
      else                      rdata_d = rd_word;
    end else if (state_q == BUSY) begin
      if (rsp_fire) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Engine state registers; a reset drops any pending response
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= GNT_IF;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Byte-enabled write commit at the acceptance edge; contents survive reset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (d_req_be[i]) mem[base + AW'(i)] <= d_req_wdata[i*8 +: 8];
      end
    end
  end

  // Response outputs are quiet (all zero) outside the strobe cycle
  always_comb begin
    if_rsp_valid = rsp_fire && (ch_q == GNT_IF);
    d_rsp_valid  = rsp_fire && (ch_q == GNT_D);
    if_rsp_data  = if_rsp_valid ? rdata_q[31:0] : '0;
    d_rsp_rdata  = d_rsp_valid ? rdata_q : '0;
    if_rsp_err   = if_rsp_valid && err_q;
    d_rsp_err    = d_rsp_valid && err_q;
    busy         = (state_q == BUSY);
  end

endmodule

// File: doc/tinker_mem_ctrl.md
# tinker_mem_ctrl

Parametrised, latency-configurable memory controller for the tinker core. It replaces the combinational single-port byte array with one shared access engine serving a 32-bit instruction-fetch channel and a DATA_BYTES-wide data channel. Both channels use valid/ready handshakes, the data channel supports byte-enable writes, and out-of-range accesses are flagged. It sits between the fetch unit and the load/store/call/return path of the core.

## Interface
- ADDR_W, 64: address width of both request channels.
- MEM_BYTES, 524288: byte capacity. Must be a power of two.
- DATA_BYTES, 8: data-channel word size in bytes. Must be a power of two, ≥4.
- LATENCY, 2: clock edges from request acceptance to response. Must be ≥1.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this edge if valid.
- if_req_addr  in  ADDR_W  fetch byte address; alignment not required.
- if_rsp_valid  out  1  one-cycle fetch response strobe.
- if_rsp_data  out  32  instruction word, little-endian.
- if_rsp_err  out  1  fetch was out of range.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted this edge if valid.
- d_req_we  in  1  1 = write, 0 = read.
- d_req_addr  in  ADDR_W  data byte address; alignment not required.
- d_req_wdata  in  DATA_BYTES*8  write data, little-endian.
- d_req_be  in  DATA_BYTES  byte enables; bit i selects byte addr+i.
- d_rsp_valid  out  1  one-cycle data response strobe (reads and writes).
- d_rsp_rdata  out  DATA_BYTES*8  read data; 0 for writes and errors.
- d_rsp_err  out  1  data access was out of range.
- busy  out  1  engine holds an outstanding access.

## Operation
- States: IDLE and BUSY. Edge counter cnt, width $clog2(LATENCY+1).
- engine_free = IDLE || (BUSY && cnt==LATENCY).
- Arbitration, combinational from the valids:
  - Only one channel valid: that channel is granted.
  - Both valid: grant the channel not granted last. The last-grant pointer resets to IF, so D wins the first tie.
- x_req_ready = engine_free && grant==x. Ready never depends on the other channel's data.
- Acceptance edge (valid && ready):
  - Range check: addr + size > MEM_BYTES is an error. Size is 4 for fetch, DATA_BYTES for data. Compute in ADDR_W+1 bits so the sum cannot wrap.
  - Reads sample all bytes into the response pipeline.
  - Writes commit the enabled bytes.
  - An erroring access reads nothing and writes nothing.
  - Next state is BUSY with cnt=1. Channel and error are latched.
- In BUSY, cnt increments each edge until it reaches LATENCY. At cnt==LATENCY, assert rsp_valid for the latched channel. At the same edge, either go to IDLE or accept a new request (back-to-back).
- Memory contents are not cleared by reset. Benches preload by hierarchical access or $readmemh.

## Timing
- Reset values: if_rsp_valid=0, d_rsp_valid=0, if_rsp_data=0, d_rsp_rdata=0, both err=0, busy=0, state=IDLE, cnt=0, pointer=IF. Readies follow the valids after reset (engine_free=1).
- Request accepted at edge t: response strobe is high for exactly one cycle, after edge t+LATENCY-1.
- Throughput: one access per LATENCY cycles. With LATENCY=1 this is full throughput.
- Read data reflects memory after all previously accepted writes. No forwarding is needed because there is a single engine.
- Simultaneous response and new acceptance in the same cycle are legal. The new access's response is independent.
- Reset asserted mid-access: the pending response is dropped and no rsp_valid is issued. A write already committed at its acceptance edge persists.
- busy is high from the acceptance edge until the edge where the response drops, unless a new access is accepted at that edge.

## Structure
- Package tinker_mem_pkg holds:
  - enum mem_state_e {IDLE, BUSY};
  - enum mem_gnt_e {GNT_IF, GNT_D};
  - localparam INST_BYTES = 4 and the default parameter values.
- Sub-module tinker_mem_arb: two-way alternating-priority arbiter containing the last-grant pointer, with grant and pointer-update logic.
- The byte array, range check and response pipeline stay in tinker_mem_ctrl.

## Test plan
- Reset: hold reset low while both valids are 1. Required: both rsp_valid=0, busy=0, no memory change. After release, d_req_ready=1 and if_req_ready=0.
- Fetch: LATENCY=2, bytes 0x2000..0x2003 preloaded with 13 57 9b df, fetch at 0x2000 accepted at edge t. Required: if_rsp_valid high for one cycle after edge t+1, if_rsp_data=0xdf9b5713, err=0.
- Masked write then read: on zeroed memory, write addr 0x2010, wdata 0x1122334455667788, be=0x0F. Then read 0x2010. Required: rdata=0x0000000055667788, and d_rsp_valid is seen for both accesses.
- Contention: both valids held high for 4 grants. Required: grant order D, IF, D, IF. With LATENCY=1, one acceptance per cycle.
- Range: DATA_BYTES=8, data read at MEM_BYTES-4. Required: d_rsp_err=1, rdata=0. Fetch at MEM_BYTES-4 returns err=0. Write at MEM_BYTES-1 leaves memory unchanged and returns err=1.
- Reset mid-op: LATENCY=3, write 0xAB to 0x3000 with be=0x01, reset pulsed after the acceptance edge. Required: no d_rsp_valid, byte 0x3000 reads back 0xAB after release.
